unidade_controle_multiciclo: RTL

//   Multicycle control FSM for the RV64 datapath (ULA, registrador, memoria, memoria_ins, PC, IR,
//   Mux1/2/4, imm_generator). Drives every write-enable and mux select that the datapath

---
 rtl/unidade_controle_multiciclo.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64 datapath: sequences fetch/decode/execute/memory/write-back
// per instruction, drives every datapath enable and mux select, and counts retired instructions.
module unidade_controle_multiciclo #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             flag,
   output logic             wePC,
   output logic             weIR,
   output logic             weReg,
   output logic             weMem,
   output logic             sinalMux1,
   output logic [1:0]       sinalMux2,
   output logic             sinalMux4,
   output logic [2:0]       estado,
   output logic             erro,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_UNUSED = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CL_R       = 3'd0,
      CL_IALU    = 3'd1,
      CL_LOAD    = 3'd2,
      CL_STORE   = 3'd3,
      CL_BRANCH  = 3'd4,
      CL_AUIPC   = 3'd5,
      CL_JAL     = 3'd6,
      CL_ILLEGAL = 3'd7
   } class_t;

   function automatic class_t classify(input logic [6:0] op);
      class_t cl;
      case (op)
         7'b0110011: cl = CL_R;
         7'b0010011: cl = CL_IALU;
         7'b0000011: cl = CL_LOAD;
         7'b0100011: cl = CL_STORE;
         7'b1100011: cl = CL_BRANCH;
         7'b0010111: cl = CL_AUIPC;
         7'b1101111: cl = CL_JAL;
         default:    cl = CL_ILLEGAL;
      endcase
      return cl;
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic [6:0]       op_q_r;
   logic [CNT_W-1:0] instret_r;
   class_t           class_s;
   logic             instr_end_s;
   state_t           boundary_s;

   // The branch decision is taken in the datapath's PC mux, so the controller never looks at flag.
   logic             flag_unused_s;
   assign flag_unused_s = flag;

   assign class_s    = classify(op_q_r);
   assign boundary_s = run ? ST_FETCH : ST_IDLE;

   // State register, latched opcode and retired-instruction counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         op_q_r    <= 7'd0;
         instret_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (state_r == ST_FETCH) begin
            op_q_r <= opcode;
         end else begin
            op_q_r <= op_q_r;
         end
         if (instr_end_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            instret_r <= instret_r;
         end
      end
   end

   // Next-state logic; run is only consulted in IDLE and at the instruction boundary
   always_comb begin
      next_state_s = ST_IDLE;
      instr_end_s  = 1'b0;
      case (state_r)
         ST_IDLE:   next_state_s = run ? ST_FETCH : ST_IDLE;
         ST_FETCH:  next_state_s = ST_DECODE;
         ST_DECODE: next_state_s = (class_s == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (class_s)
               CL_LOAD, CL_STORE: next_state_s = ST_MEM;
               CL_BRANCH: begin
                  next_state_s = boundary_s;
                  instr_end_s  = 1'b1;
               end
               default:           next_state_s = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (class_s == CL_STORE) begin
               next_state_s = boundary_s;
               instr_end_s  = 1'b1;
            end else begin
               next_state_s = ST_WB;
            end
         end
         ST_WB: begin
            next_state_s = boundary_s;
            instr_end_s  = 1'b1;
         end
         ST_TRAP:   next_state_s = ST_TRAP;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Moore outputs from state and latched opcode; selects stay stable from EXEC through WB
   always_comb begin
      wePC      = 1'b0;
      weIR      = 1'b0;
      weReg     = 1'b0;
      weMem     = 1'b0;
      sinalMux1 = 1'b0;
      sinalMux2 = 2'd0;
      sinalMux4 = 1'b0;
      erro      = 1'b0;
      case (state_r)
         ST_FETCH: weIR = 1'b1;
         ST_EXEC, ST_MEM, ST_WB: begin
            case (class_s)
               CL_R: begin
                  sinalMux1 = 1'b1;
                  sinalMux2 = 2'd1;
               end
               CL_IALU:   sinalMux2 = 2'd1;
               CL_BRANCH: sinalMux1 = 1'b1;
               CL_AUIPC: begin
                  sinalMux2 = 2'd3;
                  sinalMux4 = 1'b1;
               end
               CL_JAL: begin
                  sinalMux2 = 2'd2;
                  sinalMux4 = 1'b1;
               end
               default:   sinalMux1 = 1'b0;
            endcase
            if (state_r == ST_EXEC) begin
               wePC = (class_s == CL_BRANCH);
            end else if (state_r == ST_MEM) begin
               weMem = (class_s == CL_STORE);
               wePC  = (class_s == CL_STORE);
            end else begin
               weReg = 1'b1;
               wePC  = 1'b1;
            end
         end
         ST_TRAP:  erro = 1'b1;
         default:  erro = 1'b0;
      endcase
   end

   assign estado  = state_r;
   assign instret = instret_r;

endmodule
